// File: rtl/mjpg_packetizer.sv
// mjpg_packetizer: buffers the MJPEG encoder's unthrottled byte stream and
// re-emits it as length-prefixed packets (8-byte header + payload) on a
// valid/ready byte stream. Packets never straddle an EOI (FF D9) marker.
// Bytes that cannot be stored are dropped, and the frame is flagged corrupt.
module mjpg_packetizer #(
  parameter int ADDR_W      = 12,
  parameter int MAX_PAYLOAD = 1024,
  parameter int DESC_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jvalid,
  input  logic [7:0] jpeg,
  output logic       ovalid,
  input  logic       oready,
  output logic [7:0] odata,
  output logic       olast,
  output logic       overflow
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DDEPTH = 1 << DESC_W;
  localparam logic [ADDR_W:0] DATA_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [DESC_W:0] DESC_FULL = (DESC_W + 1)'(DDEPTH);
  localparam logic [10:0]     MAX_LEN   = 11'(MAX_PAYLOAD);

  typedef struct packed {
    logic [15:0] frame_id;
    logic [7:0]  seq;
    logic        last;
    logic        corrupt;
    logic [10:0] len;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  // Header byte idx (0..7) of the packet described by d.
  function automatic logic [7:0] hdr_byte(input desc_t d, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = 8'hA5;
      3'd1: b = 8'h5A;
      3'd2: b = d.frame_id[15:8];
      3'd3: b = d.frame_id[7:0];
      3'd4: b = d.seq;
      3'd5: b = {6'b0, d.corrupt, d.last};
      3'd6: b = {5'b0, d.len[10:8]};
      3'd7: b = d.len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Storage and pointers. Pointers carry one extra bit so full and empty
  // are distinguishable without a separate count.
  logic [7:0]      data_mem [DEPTH];
  desc_t           desc_mem [DDEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [DESC_W:0] dwr_ptr, drd_ptr;

  // Segmenter state.
  logic [7:0]  prev_byte;
  logic [10:0] seg_len;
  logic [7:0]  seq;
  logic [15:0] frame_id;
  logic        corrupt;
  logic        desc_pend;
  desc_t       pend_desc;

  // Reader state.
  state_t      state;
  desc_t       cur;
  logic [3:0]  hdr_idx;
  logic [10:0] pay_left;

  // Write-side decisions for the byte presented this cycle.
  logic [ADDR_W:0] data_used;
  logic [DESC_W:0] desc_used, desc_used_pend;
  logic            data_full, desc_full, desc_empty;
  logic [10:0]     seg_len_inc;
  logic            is_eoi, closes, accept, drop;
  desc_t           head;

  assign data_used      = wr_ptr - rd_ptr;
  assign desc_used      = dwr_ptr - drd_ptr;
  // A descriptor waiting in pend_desc already owns a slot.
  assign desc_used_pend = desc_used + {{DESC_W{1'b0}}, desc_pend};
  assign data_full      = (data_used == DATA_FULL);
  assign desc_full      = (desc_used_pend == DESC_FULL);
  assign desc_empty     = (dwr_ptr == drd_ptr);
  assign seg_len_inc    = seg_len + 11'd1;
  assign is_eoi         = (prev_byte == 8'hFF) && (jpeg == 8'hD9);
  assign closes         = is_eoi || (seg_len_inc == MAX_LEN);
  assign accept         = jvalid && !data_full && (!closes || !desc_full);
  assign drop           = jvalid && !accept;
  assign head           = desc_mem[drd_ptr[DESC_W-1:0]];

  // Payload and descriptor storage writes.
  // NOTE: the memories carry no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept)    data_mem[wr_ptr[ADDR_W-1:0]]  <= jpeg;
    if (desc_pend) desc_mem[dwr_ptr[DESC_W-1:0]] <= pend_desc;
  end

  // Segmenter: count accepted bytes, close segments, queue descriptors.
  // NOTE: all state here uses non-blocking assignments so every decision in
  // this block sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      dwr_ptr   <= '0;
      prev_byte <= 8'h00;
      seg_len   <= '0;
      seq       <= '0;
      frame_id  <= '0;
      corrupt   <= 1'b0;
      overflow  <= 1'b0;
      desc_pend <= 1'b0;
      pend_desc <= '0;
    end else begin
      desc_pend <= accept && closes;
      if (desc_pend) dwr_ptr <= dwr_ptr + 1'b1;
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prev_byte <= jpeg;
        if (closes) begin
          pend_desc <= '{frame_id: frame_id, seq: seq, last: is_eoi,
                         corrupt: corrupt, len: seg_len_inc};
          seg_len   <= '0;
          if (is_eoi) begin
            frame_id <= frame_id + 16'd1;
            seq      <= '0;
            corrupt  <= 1'b0;
          end else begin
            seq <= seq + 8'd1;
          end
        end else begin
          seg_len <= seg_len_inc;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        corrupt  <= 1'b1;
      end
    end
  end

  // Reader FSM: pop a descriptor, send its header, then its payload.
  // Outputs are registered and only advance on a transfer (or when idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ovalid   <= 1'b0;
      olast    <= 1'b0;
      odata    <= 8'h00;
      rd_ptr   <= '0;
      drd_ptr  <= '0;
      cur      <= '0;
      hdr_idx  <= '0;
      pay_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!desc_empty) begin
            cur     <= head;
            drd_ptr <= drd_ptr + 1'b1;
            ovalid  <= 1'b1;
            olast   <= 1'b0;
            odata   <= hdr_byte(head, 3'd0);
            hdr_idx <= 4'd1;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (oready) begin
            // hdr_idx counts header bytes already loaded; 8 means the last
            // header byte is the one just accepted.
            if (hdr_idx == 4'd8) begin
              odata    <= data_mem[rd_ptr[ADDR_W-1:0]];
              rd_ptr   <= rd_ptr + 1'b1;
              olast    <= (cur.len == 11'd1);
              pay_left <= cur.len - 11'd1;
              state    <= S_PAY;
            end else begin
              odata   <= hdr_byte(cur, hdr_idx[2:0]);
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        S_PAY: begin
          if (oready) begin
            if (olast) begin
              ovalid <= 1'b0;
              olast  <= 1'b0;
              state  <= S_IDLE;
            end else begin
              odata    <= data_mem[rd_ptr[ADDR_W-1:0]];
              rd_ptr   <= rd_ptr + 1'b1;
              pay_left <= pay_left - 11'd1;
              olast    <= (pay_left == 11'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
